acs_state_update: RTL

- Add-compare-select stage of the rate-1/2, K=3 Viterbi decoder.
- Sits directly downstream of the branch-metric units and consumes their per-codeword Hamming metrics (2-bit, 0..2) once per received symbol pair.
- Updates the four registered path metrics, emits one survivor decision bit per state to the traceback memory, and reports the current best state.
- Generators fixed at G1=7 (111), G0=5 (101); state s={b1,b2} holds the last two input bits.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/acs_state_update_if.sv | 27 ++
 rtl/acs_state_update_acs_unit.sv | 21 ++
 rtl/acs_state_update.sv | 111 +++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants for the rate-1/2, K=3 Viterbi ACS stage: trellis tables,
// default widths and the path-metric type.
package viterbi_pkg;

    localparam int unsigned N_STATES    = 4;
    localparam int unsigned PM_W_DEF    = 8;
    localparam int unsigned INIT_PM_DEF = 64;

    // Next state s'={u,b1}: candidate A comes from {b1,0}, candidate B from {b1,1}.
    localparam logic [1:0] PRED_A [N_STATES] = '{2'd0, 2'd2, 2'd0, 2'd2};
    localparam logic [1:0] PRED_B [N_STATES] = '{2'd1, 2'd3, 2'd1, 2'd3};
    // Codeword {c1,c0} on each branch, used to pick the branch metric.
    localparam logic [1:0] CW_A   [N_STATES] = '{2'd0, 2'd2, 2'd3, 2'd1};
    localparam logic [1:0] CW_B   [N_STATES] = '{2'd3, 2'd1, 2'd0, 2'd2};

    typedef logic [PM_W_DEF-1:0] pm_t;

endpackage

// File: rtl/acs_state_update_if.sv
// Branch-metric input / path-metric output bundle of the ACS stage.
interface acs_state_update_if
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = PM_W_DEF
);
    logic                       init;
    logic                       in_valid;
    logic [1:0]                 bm_00;
    logic [1:0]                 bm_01;
    logic [1:0]                 bm_10;
    logic [1:0]                 bm_11;
    logic                       out_valid;
    logic [N_STATES-1:0]        dec;
    logic [N_STATES*PM_W-1:0]   pm;
    logic [1:0]                 best_state;

    modport master (
        output init, in_valid, bm_00, bm_01, bm_10, bm_11,
        input  out_valid, dec, pm, best_state
    );

    modport slave (
        input  init, in_valid, bm_00, bm_01, bm_10, bm_11,
        output out_valid, dec, pm, best_state
    );
endinterface

// File: rtl/acs_state_update_acs_unit.sv
// One add-compare-select cell: two candidates at PM_W+1 bits, ties keep A.
module acs_unit #(
    parameter int unsigned PM_W = 8
) (
    input  logic [PM_W-1:0] i_pm_a,
    input  logic [PM_W-1:0] i_pm_b,
    input  logic [1:0]      i_bm_a,
    input  logic [1:0]      i_bm_b,
    output logic [PM_W:0]   o_pm_new,
    output logic            o_dec
);
    logic [PM_W:0] w_cand_a;
    logic [PM_W:0] w_cand_b;

    always_comb begin
        w_cand_a = {1'b0, i_pm_a} + {{(PM_W-1){1'b0}}, i_bm_a};
        w_cand_b = {1'b0, i_pm_b} + {{(PM_W-1){1'b0}}, i_bm_b};
        o_dec    = (w_cand_b < w_cand_a);
        o_pm_new = o_dec ? w_cand_b : w_cand_a;
    end
endmodule

// File: rtl/acs_state_update.sv
// ACS stage of the K=3 Viterbi decoder: four ACS cells, metric normalisation,
// best-state selection and the registered path metrics.
module acs_state_update
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W    = PM_W_DEF,
    parameter int unsigned INIT_PM = INIT_PM_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    acs_state_update_if.slave bus
);
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);

    logic [PM_W-1:0]     r_pm [N_STATES];
    logic [N_STATES-1:0] r_dec;
    logic [1:0]          r_best;
    logic                r_out_valid;

    logic [1:0]          w_bm       [N_STATES];
    logic [PM_W:0]       w_new      [N_STATES];
    logic [PM_W-1:0]     w_norm     [N_STATES];
    logic [N_STATES-1:0] w_dec;
    logic [N_STATES-1:0] w_top_bits;
    logic [N_STATES-1:0] w_ovf;
    logic [1:0]          w_idx_lo;
    logic [1:0]          w_idx_hi;
    logic [1:0]          w_best;

    always_comb begin
        w_bm[0] = bus.bm_00;
        w_bm[1] = bus.bm_01;
        w_bm[2] = bus.bm_10;
        w_bm[3] = bus.bm_11;
    end

    for (genvar g = 0; g < N_STATES; g++) begin : g_acs
        acs_unit #(.PM_W(PM_W)) u_acs (
            .i_pm_a   (r_pm[PRED_A[g]]),
            .i_pm_b   (r_pm[PRED_B[g]]),
            .i_bm_a   (w_bm[CW_A[g]]),
            .i_bm_b   (w_bm[CW_B[g]]),
            .o_pm_new (w_new[g]),
            .o_dec    (w_dec[g])
        );
    end

    // Clearing the MSB in all four only when all have it set keeps differences intact.
    always_comb begin
        w_top_bits = '0;
        w_ovf      = '0;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            w_top_bits[i] = w_new[i][PM_W-1];
            w_ovf[i]      = w_new[i][PM_W];
        end
        for (int unsigned i = 0; i < N_STATES; i++) begin
            w_norm[i] = w_new[i][PM_W-1:0];
            if (&w_top_bits) begin
                w_norm[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Two-level minimum tree; strict compares keep the lower index on ties.
    always_comb begin
        w_idx_lo = (w_norm[1] < w_norm[0]) ? 2'd1 : 2'd0;
        w_idx_hi = (w_norm[3] < w_norm[2]) ? 2'd3 : 2'd2;
        w_best   = (w_norm[w_idx_hi] < w_norm[w_idx_lo]) ? w_idx_hi : w_idx_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_STATES; i++) begin
                r_pm[i] <= (i == 0) ? '0 : PM_INIT;
            end
            r_dec       <= '0;
            r_best      <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.init) begin
            for (int unsigned i = 0; i < N_STATES; i++) begin
                r_pm[i] <= (i == 0) ? '0 : PM_INIT;
            end
            r_dec       <= '0;
            r_best      <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            for (int unsigned i = 0; i < N_STATES; i++) begin
                r_pm[i] <= w_norm[i];
            end
            r_dec       <= w_dec;
            r_best      <= w_best;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        bus.pm = '0;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            bus.pm[i*PM_W +: PM_W] = r_pm[i];
        end
        bus.dec        = r_dec;
        bus.best_state = r_best;
        bus.out_valid  = r_out_valid;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.in_valid && !bus.init) |-> (w_ovf == '0));

endmodule
